// File: rtl/axis_usb_packetiser.sv
// Re-frames a byte AXI-Stream into bulk-IN packets of at most MAX_PKT bytes; 2-cycle latency from a tlast write to m_tvalid.
// Upstream is stalled only when the FIFO is full; downstream stalls hold the head byte and tlast stable.
module axis_usb_packetiser #(
    parameter int DEPTH   = 2048,
    parameter int MAX_PKT = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid_i,
    output logic                   s_axis_tready_o,
    input  logic                   s_axis_tlast_i,
    input  logic [7:0]             s_axis_tdata_i,
    output logic                   m_axis_tvalid_o,
    input  logic                   m_axis_tready_i,
    output logic                   m_axis_tlast_o,
    output logic [7:0]             m_axis_tdata_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(MAX_PKT) + 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_PKT);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [TW-1:0] TO_L    = TW'(TIMEOUT);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state, w_state_nxt;
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level, w_level_nxt;
    logic [LW-1:0] r_pend, w_pend_nxt;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_rem, w_rem_nxt;
    logic          r_s_rdy;
    logic          w_wr, w_rd, w_last, w_trig;
    logic [8:0]    w_head;

    assign w_head = r_mem[r_rd_ptr];
    assign w_wr   = s_axis_tvalid_i & r_s_rdy;
    assign w_rd   = (r_state == SEND) & m_axis_tready_i;
    assign w_last = (r_rem == RW'(1)) | w_head[8];
    assign w_trig = (r_level >= MAX_L) | (r_pend != '0) | ((TIMEOUT != 0) && (r_timer == TO_L));

    assign s_axis_tready_o = r_s_rdy;
    assign m_axis_tvalid_o = (r_state == SEND);
    assign m_axis_tlast_o  = (r_state == SEND) & w_last;
    assign m_axis_tdata_o  = (r_state == SEND) ? w_head[7:0] : 8'h00;
    assign level_o         = r_level;

    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {s_axis_tlast_i, s_axis_tdata_i};
    end

    always_comb begin
        w_level_nxt = r_level;
        w_pend_nxt  = r_pend;
        if (w_wr && !w_rd) w_level_nxt = r_level + LW'(1);
        else if (!w_wr && w_rd) w_level_nxt = r_level - LW'(1);
        if ((w_wr && s_axis_tlast_i) && !(w_rd && w_head[8])) w_pend_nxt = r_pend + LW'(1);
        else if (!(w_wr && s_axis_tlast_i) && (w_rd && w_head[8])) w_pend_nxt = r_pend - LW'(1);
    end

    // Ready is registered from the next level so it is low throughout reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_pend   <= '0;
            r_timer  <= '0;
            r_s_rdy  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_pend  <= w_pend_nxt;
            r_s_rdy <= (w_level_nxt < DEPTH_L);
            if (w_wr || (r_state != IDLE) || (r_level == '0)) r_timer <= '0;
            else if (r_timer != TO_L) r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Length is bounded by the level at latch time, so the FIFO never runs dry mid-packet.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_rem_nxt   = (r_level >= MAX_L) ? RW'(MAX_PKT) : r_level[RW-1:0];
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_rd) begin
                    w_rem_nxt = r_rem - RW'(1);
                    if (w_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axis_usb_packetiser.sv
// Bench for axis_usb_packetiser: scoreboard of {tlast,data} pushed at write time, popped on downstream handshakes.
module tb_axis_usb_packetiser;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  s_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [7:0]  m_tdata;
    logic [11:0] level;
    logic        b_en, b_s_tready, b_m_tvalid, b_m_tlast;
    logic [7:0]  b_m_tdata;
    logic [11:0] b_level;
    logic        m_rdy_fixed, rand_en, r_rnd, chk_lvl, saw_full, prev_last;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          pops, lvl_model;
    logic [8:0]  exp_q [$];

    always #5 aclk = ~aclk;

    assign m_tready = rand_en ? r_rnd : m_rdy_fixed;

    always @(posedge aclk) begin
        #1;
        r_rnd = ($urandom_range(0, 99) < 30);
    end

    axis_usb_packetiser #(.DEPTH(2048), .MAX_PKT(512), .TIMEOUT(100)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
        .s_axis_tlast_i(s_tlast), .s_axis_tdata_i(s_tdata),
        .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
        .m_axis_tlast_o(m_tlast), .m_axis_tdata_o(m_tdata),
        .level_o(level)
    );

    axis_usb_packetiser #(.DEPTH(2048), .MAX_PKT(512), .TIMEOUT(0)) u_dut_nt (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid_i(s_tvalid & b_en), .s_axis_tready_o(b_s_tready),
        .s_axis_tlast_i(s_tlast), .s_axis_tdata_i(s_tdata),
        .m_axis_tvalid_o(b_m_tvalid), .m_axis_tready_i(1'b1),
        .m_axis_tlast_o(b_m_tlast), .m_axis_tdata_o(b_m_tdata),
        .level_o(b_level)
    );

    task automatic monitor();
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                lvl_model = 0;
                prev_last = 1'b0;
            end else begin
                if (m_tvalid) begin
                    tests_run++;
                    if (prev_last) begin
                        tests_failed++;
                        $display("FAIL gap: m_tvalid=1 right after a packet end, required 0");
                    end
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL data: got last=%0b data=%h, required no output", m_tlast, m_tdata);
                    end else if ({m_tlast, m_tdata} !== exp_q[0]) begin
                        tests_failed++;
                        $display("FAIL data: got last=%0b data=%h, required last=%0b data=%h",
                                 m_tlast, m_tdata, exp_q[0][8], exp_q[0][7:0]);
                    end
                    if (m_tready && exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
                prev_last = m_tvalid & m_tready & m_tlast;
                if (chk_lvl) begin
                    tests_run++;
                    if (level !== 12'(lvl_model) || s_tready !== (lvl_model < 2048)) begin
                        tests_failed++;
                        $display("FAIL level: got level=%0d s_tready=%0b, required level=%0d s_tready=%0b",
                                 level, s_tready, lvl_model, (lvl_model < 2048));
                    end
                    if (level == 12'd2048) saw_full = 1'b1;
                    lvl_model = lvl_model + int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
                end
                if (b_en) begin
                    tests_run++;
                    if (b_m_tvalid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL no_timeout: m_tvalid=%0b with TIMEOUT=0, required 0", b_m_tvalid);
                    end
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic el);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (s_tready !== 1'b1 && n < 5000) begin
            @(posedge aclk); #1;
            n++;
        end
        if (s_tready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push: s_tready=%0b after %0d cycles, required 1", s_tready, n);
            s_tvalid = 1'b0;
            return;
        end
        exp_q.push_back({el, d});
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge aclk); #1;
            n++;
        end
        repeat (2) begin @(posedge aclk); #1; end
        tests_run++;
        if (exp_q.size() != 0 || level !== 12'd0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d bytes outstanding level_o=%0d, required 0 and 0", name, exp_q.size(), level);
        end
    endtask

    task automatic test_reset();
        #2 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        tests_run++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready} !== 11'd0 || level !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset: got tvalid=%0b tlast=%0b tdata=%h s_tready=%0b level=%0d, required all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, level);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        tests_run++;
        if (s_tready !== 1'b1 || level !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got s_tready=%0b level=%0d, required 1 and 0", s_tready, level);
        end
    endtask

    task automatic test_long_frame();
        m_rdy_fixed = 1'b1;
        for (int i = 0; i < 1200; i++)
            push(8'(i), (i == 1199), (i == 511 || i == 1023 || i == 1199));
        wait_drain("long_frame");
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < 9; i++) push(8'(8'hA0 + i), 1'b0, 1'b0);
        push(8'hA9, 1'b1, 1'b1);
        tests_run++;
        if (m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: m_tvalid=%0b one cycle after tlast write, required 0", m_tvalid);
        end
        @(posedge aclk); #1;
        tests_run++;
        if (m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency: m_tvalid=%0b two cycles after tlast write, required 1", m_tvalid);
        end
        wait_drain("short_frame");
    endtask

    task automatic test_timeout();
        int cnt;
        b_en = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0, (i == 4));
        cnt = 0;
        while (m_tvalid !== 1'b1 && cnt < 300) begin
            @(posedge aclk); #1;
            cnt++;
        end
        tests_run++;
        if (cnt != 101) begin
            tests_failed++;
            $display("FAIL timeout_latency: m_tvalid after %0d cycles, required 101", cnt);
        end
        wait_drain("timeout");
        tests_run++;
        if (b_level !== 12'd5 || b_s_tready !== 1'b1 || {b_m_tlast, b_m_tdata} !== 9'd0) begin
            tests_failed++;
            $display("FAIL no_timeout_hold: got level=%0d s_tready=%0b last/data=%h, required 5 1 0",
                     b_level, b_s_tready, {b_m_tlast, b_m_tdata});
        end
        b_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push(8'(8'h10 + i), (i == 2), (i == 2));
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i), (i == 3), (i == 3));
        wait_drain("back_to_back");
    endtask

    task automatic test_backpressure();
        lvl_model = 0;
        saw_full  = 1'b0;
        chk_lvl   = 1'b1;
        rand_en   = 1'b1;
        for (int i = 0; i < 4096; i++)
            push(8'(i) ^ 8'h5A, (i == 4095), ((i % 512) == 511));
        wait_drain("backpressure");
        chk_lvl = 1'b0;
        rand_en = 1'b0;
        tests_run++;
        if (saw_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill: level_o reached 2048 = %0b, required 1", saw_full);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        m_rdy_fixed = 1'b0;
        for (int i = 0; i < 600; i++) push(8'(i), 1'b0, (i == 511));
        pops = 0;
        n = 0;
        m_rdy_fixed = 1'b1;
        while (pops < 200 && n < 2000) begin
            @(posedge aclk); #1;
            n++;
        end
        tests_run++;
        if (m_tvalid !== 1'b1 || level !== 12'd400) begin
            tests_failed++;
            $display("FAIL mid_send: got tvalid=%0b level=%0d, required 1 and 400", m_tvalid, level);
        end
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || level !== 12'd0 || s_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got tvalid=%0b level=%0d s_tready=%0b, required 0 0 0",
                     m_tvalid, level, s_tready);
        end
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i), (i == 7), (i == 7));
        wait_drain("after_reset");
    endtask

    initial begin
        aresetn     = 1'b1;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = 8'h00;
        b_en        = 1'b0;
        m_rdy_fixed = 1'b0;
        rand_en     = 1'b0;
        chk_lvl     = 1'b0;
        saw_full    = 1'b0;
        prev_last   = 1'b0;
        pops        = 0;
        lvl_model   = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_long_frame();
        test_short_frame();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
